alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issuing-side controller for the combinational 16-bit ALU: accepts 16-bit instruction words over a valid/ready handshake, reads operands from an internal 8×16 register file, drives the ALU's operand and opcode inputs, captures the result and flags, and writes the result back. It sits between a host or instruction source and the ALU, and is the only driver of the ALU inputs.

## Interface
- DATA_W, 16, datapath and register width
- NREGS, 8, register-file depth (index width 3)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  sequencer can accept an instruction
- in_instr  in  16  instruction: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved (ignored)
- wr_en / wr_addr / wr_data  in  1/3/16  host register write
- rd_addr  in  3  host read index; rd_data out 16, combinational read of the register file
- alu_a, alu_b  out  16  registered ALU operands
- alu_op  out  4  registered ALU opcode
- alu_r  in  16  ALU result
- alu_c, alu_z  in  1  ALU compare flags
- done  out  1  one-cycle pulse: instruction retired
- flag_c, flag_z  out  1  sequencer flag registers
- err  out  1  sticky divide-by-zero indicator (only with ALU_SEQ_DIVZ_TRAP_EN)

## Operation
- States: IDLE, ISSUE, WB.
- IDLE: in_ready = (state==IDLE) && !wr_en. The host write takes priority, and no instruction is accepted in a cycle with wr_en high. On in_valid && in_ready, the sequencer latches opcode and rd, loads alu_a=R[ra], alu_b=R[rb], alu_op=opcode, and moves to ISSUE.
- ISSUE: the ALU settles combinationally. At the next edge the sequencer samples alu_r, alu_c and alu_z, then moves to WB.
- WB: for opcodes 0000–1110, R[rd] is written with the sampled alu_r and flag_z = (alu_r==0); flag_c is unchanged. For opcode 1111 (compare) there is no register write; flag_c=alu_c and flag_z=alu_z. done pulses for one cycle, then the state returns to IDLE.
- Unary ops (0011, 0100, 1010, 1011) still read rb; the value is ignored by the ALU.
- Same register as ra/rb and rd is allowed; operands are the values read in IDLE.
- wr_en outside IDLE is ignored (dropped, not queued).
- Results are truncated to 16 bits. The sequencer applies no arithmetic of its own.
- Reset (asynchronous, any state): state=IDLE, every register-file entry=0, alu_a=alu_b=0, alu_op=0000, done=0, flag_c=flag_z=0, err=0. An instruction in flight at reset is abandoned with no writeback and no done.

## Timing
- Accept edge E0 → ALU inputs valid from E0 through E1 → result captured at E1 → register write and done in the WB cycle (E1–E2) → in_ready high again after E2.
- Latency from accept to done is 2 cycles. Throughput is 1 instruction per 3 cycles.
- rd_data shows a WB write from the edge ending WB onward.
- A host write takes effect at the edge where wr_en is sampled in IDLE.

## Configuration
- ALU_SEQ_DIVZ_TRAP_EN defined: for opcode 0010 with alu_b==0, WB suppresses the register write and flag update, sets err (sticky until reset), and still pulses done.
- Macro undefined: the err port is tied to 0, and divide-by-zero writes whatever alu_r presents, like any other opcode.

## Structure
- Package alu_seq_pkg holds the opcode constants (OP_ADD … OP_CMP), instruction field positions, and the state enum.
- Sub-module alu_seq_regfile: 8×16 registers with three combinational read ports (ra, rb, host) and one write port. The write port is muxed between the host write in IDLE and the sequencer write in WB, with async clear.
- The ALU is instantiated outside this block.

## Test plan
- Reset then idle: all outputs 0, in_ready=1, rd_data=0 for all indices.
- Host writes R1=0x0005 and R2=0x0003, then ADD rd=3 ra=1 rb=2 → alu_op=0000 during ISSUE, done 2 cycles after accept, R3=0x0008, flag_z=0.
- SUB rd=4 ra=1 rb=1 → R4=0x0000, flag_z=1. Then CMP with R1=0x0003, R2=0x0005 and an ALU model giving c=1 → flag_c=1, R unchanged.
- in_valid held high continuously: accepts exactly every 3 cycles. wr_en raised in IDLE with in_valid → in_ready=0, write lands, instruction accepted the following cycle.
- DIV rd=5 ra=1 rb=6 with R6=0: with the macro, R5 keeps its old value, err=1, done pulses. Without the macro, R5 = alu_r and err=0.
- Assert rst during ISSUE → no write to rd, no done, everything at reset values next cycle.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU sequencer:
//   - datapath and register-file geometry
//   - ALU opcode constants
//   - instruction-word field positions
//   - sequencer state encoding
// No ports; import with alu_seq_pkg::*.
// ----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam int DATA_W = 16;
   localparam int NREGS  = 8;
   localparam int IDX_W  = 3;

   // ALU opcodes. NOT, NEG, INC and DEC are unary and ignore operand b.
   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_DIV = 4'b0010;
   localparam logic [3:0] OP_NOT = 4'b0011;
   localparam logic [3:0] OP_NEG = 4'b0100;
   localparam logic [3:0] OP_AND = 4'b0101;
   localparam logic [3:0] OP_OR  = 4'b0110;
   localparam logic [3:0] OP_XOR = 4'b0111;
   localparam logic [3:0] OP_SHL = 4'b1000;
   localparam logic [3:0] OP_SHR = 4'b1001;
   localparam logic [3:0] OP_INC = 4'b1010;
   localparam logic [3:0] OP_DEC = 4'b1011;
   localparam logic [3:0] OP_MUL = 4'b1100;
   localparam logic [3:0] OP_REM = 4'b1101;
   localparam logic [3:0] OP_MAX = 4'b1110;
   localparam logic [3:0] OP_CMP = 4'b1111;

   // Instruction word: [15:12] opcode, [11:9] rd, [8:6] ra, [5:3] rb, [2:0] reserved.
   localparam int INSTR_OP_MSB = 15;
   localparam int INSTR_OP_LSB = 12;
   localparam int INSTR_RD_MSB = 11;
   localparam int INSTR_RD_LSB = 9;
   localparam int INSTR_RA_MSB = 8;
   localparam int INSTR_RA_LSB = 6;
   localparam int INSTR_RB_MSB = 5;
   localparam int INSTR_RB_LSB = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WB    = 2'd2
   } state_e;

endpackage

// File: rtl/alu_seq_regfile.sv
// ----------------------------------------------------------------------------
// alu_seq_regfile
// 8 x 16 register file for the ALU sequencer.
//   clk, rst              clock, asynchronous active-high clear of all entries
//   ra_addr  -> ra_data   combinational operand-a read
//   rb_addr  -> rb_data   combinational operand-b read
//   host_raddr -> host_rdata  combinational host read
//   host_we/host_waddr/host_wdata  host write (caller qualifies with IDLE)
//   seq_we/seq_waddr/seq_wdata     sequencer writeback (WB only)
// Host and sequencer writes are never active together; the sequencer write
// is given priority in the mux only so the choice is explicit.
// ----------------------------------------------------------------------------
module alu_seq_regfile
   import alu_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [IDX_W-1:0]  ra_addr,
   input  logic [IDX_W-1:0]  rb_addr,
   input  logic [IDX_W-1:0]  host_raddr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              host_we,
   input  logic [IDX_W-1:0]  host_waddr,
   input  logic [DATA_W-1:0] host_wdata,
   input  logic              seq_we,
   input  logic [IDX_W-1:0]  seq_waddr,
   input  logic [DATA_W-1:0] seq_wdata
);

   logic [DATA_W-1:0] mem_q [NREGS];
   logic [DATA_W-1:0] mem_d [NREGS];

   assign ra_data    = mem_q[ra_addr];
   assign rb_data    = mem_q[rb_addr];
   assign host_rdata = mem_q[host_raddr];

   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
      for (int i = 0; i < NREGS; i++) mem_d[i] = mem_q[i];
      if (seq_we)
         mem_d[seq_waddr] = seq_wdata;
      else if (host_we)
         mem_d[host_waddr] = host_wdata;
   end

   // NOTE: this storage is cleared by reset because software relies on all-zero registers; that forces flops instead of a RAM macro.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
      end else begin
         // NOTE: sequential state is assigned with <= so every flop samples pre-edge values, independent of statement order.
         for (int i = 0; i < NREGS; i++) mem_q[i] <= mem_d[i];
      end
   end

endmodule

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Issuing-side controller for an external combinational 16-bit ALU.
// Accepts an instruction (valid/ready), reads R[ra]/R[rb], drives registered
// ALU inputs, captures the result one cycle later and writes it back.
// IDLE -> ISSUE -> WB -> IDLE: 2-cycle latency, one instruction per 3 cycles.
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr     instruction handshake
//   wr_en/wr_addr/wr_data          host register write (honoured in IDLE only)
//   rd_addr/rd_data                combinational host register read
//   alu_a/alu_b/alu_op             registered ALU inputs
//   alu_r/alu_c/alu_z              ALU result and compare flags
//   done                           one-cycle pulse in the WB cycle
//   flag_c/flag_z                  sequencer flag registers
//   err                            sticky divide-by-zero indicator
// Build option: define ALU_SEQ_DIVZ_TRAP_EN to trap DIV with alu_b==0
// (no writeback, no flag update, err set). Otherwise err is tied low.
// ----------------------------------------------------------------------------
module alu_sequencer
   import alu_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_instr,
   input  logic        wr_en,
   input  logic [2:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [2:0]  rd_addr,
   output logic [15:0] rd_data,
   output logic [15:0] alu_a,
   output logic [15:0] alu_b,
   output logic [3:0]  alu_op,
   input  logic [15:0] alu_r,
   input  logic        alu_c,
   input  logic        alu_z,
   output logic        done,
   output logic        flag_c,
   output logic        flag_z,
   output logic        err
);

   state_e            state_q, state_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [IDX_W-1:0]  rd_q, rd_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              res_c_q, res_c_d;
   logic              res_z_q, res_z_d;
   logic              flag_c_q, flag_c_d;
   logic              flag_z_q, flag_z_d;

   logic [DATA_W-1:0] ra_data, rb_data;
   logic              seq_we;
   logic              divz_trap;

   // Reserved instruction bits are deliberately ignored.
   logic              unused_instr_bits;
   assign unused_instr_bits = ^in_instr[2:0];

   assign in_ready = (state_q == ST_IDLE) && !wr_en;
   assign done     = (state_q == ST_WB);
   assign alu_a    = alu_a_q;
   assign alu_b    = alu_b_q;
   assign alu_op   = alu_op_q;
   assign flag_c   = flag_c_q;
   assign flag_z   = flag_z_q;

`ifdef ALU_SEQ_DIVZ_TRAP_EN
   logic err_q, err_d;
   assign err       = err_q;
   // alu_b_q still holds the divisor during WB.
   assign divz_trap = (alu_op_q == OP_DIV) && (alu_b_q == '0);
`else
   assign err       = 1'b0;
   assign divz_trap = 1'b0;
`endif

   alu_seq_regfile u_regfile (
      .clk        (clk),
      .rst        (rst),
      .ra_addr    (in_instr[INSTR_RA_MSB:INSTR_RA_LSB]),
      .rb_addr    (in_instr[INSTR_RB_MSB:INSTR_RB_LSB]),
      .host_raddr (rd_addr),
      .ra_data    (ra_data),
      .rb_data    (rb_data),
      .host_rdata (rd_data),
      .host_we    (wr_en && (state_q == ST_IDLE)),
      .host_waddr (wr_addr),
      .host_wdata (wr_data),
      .seq_we     (seq_we),
      .seq_waddr  (rd_q),
      .seq_wdata  (res_q)
   );

   always_comb begin
      state_d  = state_q;
      alu_op_d = alu_op_q;
      rd_d     = rd_q;
      alu_a_d  = alu_a_q;
      alu_b_d  = alu_b_q;
      res_d    = res_q;
      res_c_d  = res_c_q;
      res_z_d  = res_z_q;
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      seq_we   = 1'b0;
`ifdef ALU_SEQ_DIVZ_TRAP_EN
      err_d    = err_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (in_valid && in_ready) begin
               alu_op_d = in_instr[INSTR_OP_MSB:INSTR_OP_LSB];
               rd_d     = in_instr[INSTR_RD_MSB:INSTR_RD_LSB];
               alu_a_d  = ra_data;
               alu_b_d  = rb_data;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            res_d   = alu_r;
            res_c_d = alu_c;
            res_z_d = alu_z;
            state_d = ST_WB;
         end
         ST_WB: begin
            state_d = ST_IDLE;
            if (divz_trap) begin
`ifdef ALU_SEQ_DIVZ_TRAP_EN
               err_d = 1'b1;
`endif
            end else if (alu_op_q == OP_CMP) begin
               flag_c_d = res_c_q;
               flag_z_d = res_z_q;
            end else begin
               seq_we   = 1'b1;
               flag_z_d = (res_q == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         alu_op_q <= OP_ADD;
         rd_q     <= '0;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
         res_q    <= '0;
         res_c_q  <= 1'b0;
         res_z_q  <= 1'b0;
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
`ifdef ALU_SEQ_DIVZ_TRAP_EN
         err_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         alu_op_q <= alu_op_d;
         rd_q     <= rd_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
         res_q    <= res_d;
         res_c_q  <= res_c_d;
         res_z_q  <= res_z_d;
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
`ifdef ALU_SEQ_DIVZ_TRAP_EN
         err_q    <= err_d;
`endif
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
// Directed testbench for alu_sequencer with a small behavioural ALU
// (ADD, SUB, DIV with /0 -> 0xFFFF, CMP c=a<b z=a==b).
// Honours ALU_SEQ_DIVZ_TRAP_EN for the divide-by-zero expectations.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_instr;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  rd_addr;
   logic [15:0] rd_data;
   logic [15:0] alu_a, alu_b;
   logic [3:0]  alu_op;
   logic [15:0] alu_r;
   logic        alu_c, alu_z;
   logic        done, flag_c, flag_z, err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_instr (in_instr),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_op   (alu_op),
      .alu_r    (alu_r),
      .alu_c    (alu_c),
      .alu_z    (alu_z),
      .done     (done),
      .flag_c   (flag_c),
      .flag_z   (flag_z),
      .err      (err)
   );

   // Behavioural ALU.
   always_comb begin
      alu_r = 16'h0000;
      alu_c = 1'b0;
      alu_z = 1'b0;
      case (alu_op)
         4'b0000: alu_r = alu_a + alu_b;
         4'b0001: alu_r = alu_a - alu_b;
         4'b0010: alu_r = (alu_b == 16'h0000) ? 16'hFFFF : alu_a / alu_b;
         4'b1111: begin
            alu_c = (alu_a < alu_b);
            alu_z = (alu_a == alu_b);
         end
         default: alu_r = 16'h0000;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [2:0] a, input logic [15:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [2:0] a, input logic [15:0] exp);
      rd_addr = a;
      #1;
      check(tag, {16'h0, rd_data}, {16'h0, exp});
   endtask

   // Issue one instruction and check ALU drive and done timing.
   task automatic run_instr(input string tag, input logic [3:0] op, input logic [2:0] rd,
                            input logic [2:0] ra, input logic [2:0] rb,
                            input logic [15:0] ea, input logic [15:0] eb);
      int n;
      in_instr = {op, rd, ra, rb, 3'b101};
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0;
      check({tag, "_alu_op"}, {28'h0, alu_op}, {28'h0, op});
      check({tag, "_alu_a"}, {16'h0, alu_a}, {16'h0, ea});
      check({tag, "_alu_b"}, {16'h0, alu_b}, {16'h0, eb});
      check({tag, "_done_issue"}, {31'h0, done}, 32'h0);
      tick();
      check({tag, "_done_wb"}, {31'h0, done}, 32'h1);
      tick();
      check({tag, "_done_after"}, {31'h0, done}, 32'h0);
      check({tag, "_ready_after"}, {31'h0, in_ready}, 32'h1);
   endtask

   initial begin
      logic exp_ready [9];
      rst      = 1'b1;
      in_valid = 1'b0;
      in_instr = 16'h0000;
      wr_en    = 1'b0;
      wr_addr  = 3'd0;
      wr_data  = 16'h0000;
      rd_addr  = 3'd0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      check("rst_in_ready", {31'h0, in_ready}, 32'h1);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_alu_a", {16'h0, alu_a}, 32'h0);
      check("rst_alu_b", {16'h0, alu_b}, 32'h0);
      check("rst_alu_op", {28'h0, alu_op}, 32'h0);
      check("rst_flags", {30'h0, flag_c, flag_z}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      for (int i = 0; i < 8; i++) check_reg($sformatf("rst_r%0d", i), 3'(i), 16'h0000);

      // ADD R3 = R1 + R2.
      host_write(3'd1, 16'h0005);
      host_write(3'd2, 16'h0003);
      check_reg("hw_r1", 3'd1, 16'h0005);
      run_instr("add", 4'b0000, 3'd3, 3'd1, 3'd2, 16'h0005, 16'h0003);
      check_reg("add_r3", 3'd3, 16'h0008);
      check("add_flag_z", {31'h0, flag_z}, 32'h0);

      // SUB R4 = R1 - R1 -> zero.
      run_instr("sub", 4'b0001, 3'd4, 3'd1, 3'd1, 16'h0005, 16'h0005);
      check_reg("sub_r4", 3'd4, 16'h0000);
      check("sub_flag_z", {31'h0, flag_z}, 32'h1);
      check("sub_flag_c", {31'h0, flag_c}, 32'h0);

      // CMP 3 vs 5: c=1, z=0, no register write.
      host_write(3'd1, 16'h0003);
      host_write(3'd2, 16'h0005);
      run_instr("cmp", 4'b1111, 3'd7, 3'd1, 3'd2, 16'h0003, 16'h0005);
      check("cmp_flag_c", {31'h0, flag_c}, 32'h1);
      check("cmp_flag_z", {31'h0, flag_z}, 32'h0);
      check_reg("cmp_r7", 3'd7, 16'h0000);

      // in_valid held high: accepts exactly every 3 cycles.
      for (int i = 0; i < 9; i++) exp_ready[i] = (i % 3 == 0);
      in_instr = {4'b0000, 3'd7, 3'd1, 3'd2, 3'b000};
      in_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         check($sformatf("tput_ready_c%0d", i), {31'h0, in_ready}, {31'h0, exp_ready[i]});
         tick();
      end
      in_valid = 1'b0;
      check_reg("tput_r7", 3'd7, 16'h0008);
      check("tput_idle", {31'h0, in_ready}, 32'h1);

      // Host write and instruction in the same IDLE cycle: write wins.
      wr_en    = 1'b1;
      wr_addr  = 3'd5;
      wr_data  = 16'h1234;
      in_valid = 1'b1;
      in_instr = {4'b0000, 3'd0, 3'd5, 3'd2, 3'b000};
      #1;
      check("wr_blocks_ready", {31'h0, in_ready}, 32'h0);
      tick();
      wr_en = 1'b0;
      check_reg("wr_r5", 3'd5, 16'h1234);
      check("wr_then_ready", {31'h0, in_ready}, 32'h1);
      tick();
      in_valid = 1'b0;
      check("wr_acc_alu_a", {16'h0, alu_a}, 32'h1234);
      check("wr_acc_alu_b", {16'h0, alu_b}, 32'h0005);
      // wr_en outside IDLE must be dropped.
      host_write(3'd6, 16'hBEEF);
      tick();
      check_reg("wr_r0", 3'd0, 16'h1239);
      check_reg("wr_drop_r6", 3'd6, 16'h0000);

      // DIV by zero: R5 = R1 / R6 with R6 = 0.
      run_instr("div", 4'b0010, 3'd5, 3'd1, 3'd6, 16'h0003, 16'h0000);
`ifdef ALU_SEQ_DIVZ_TRAP_EN
      check_reg("divz_r5", 3'd5, 16'h1234);
      check("divz_err", {31'h0, err}, 32'h1);
      check("divz_flag_z", {31'h0, flag_z}, 32'h0);
`else
      check_reg("divz_r5", 3'd5, 16'hFFFF);
      check("divz_err", {31'h0, err}, 32'h0);
      check("divz_flag_z", {31'h0, flag_z}, 32'h0);
`endif

      // Reset during ISSUE abandons the instruction.
      in_instr = {4'b0000, 3'd2, 3'd1, 3'd1, 3'b000};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("rst_issue_alu_a", {16'h0, alu_a}, 32'h0003);
      rst = 1'b1;
      #1;
      check("rst_async_done", {31'h0, done}, 32'h0);
      tick();
      check("rst_hold_done", {31'h0, done}, 32'h0);
      rst = 1'b0;
      tick();
      check("rst2_done", {31'h0, done}, 32'h0);
      check("rst2_ready", {31'h0, in_ready}, 32'h1);
      check("rst2_alu", {alu_a, alu_b}, 32'h0);
      check("rst2_alu_op", {28'h0, alu_op}, 32'h0);
      check("rst2_flags", {30'h0, flag_c, flag_z}, 32'h0);
      check("rst2_err", {31'h0, err}, 32'h0);
      for (int i = 0; i < 8; i++) check_reg($sformatf("rst2_r%0d", i), 3'(i), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
